alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one ALU1 instance between two requesters, REQ0 and REQ1, using round-robin arbitration.
- Latches the winning requester's operand bundle and drives it onto the ALU ports.
- Waits the op-dependent ALU latency: 2 cycles for normal ops, 3 cycles for the multiply commands.
- Captures RES and flags, then returns them with a DONE pulse tagged with the requester ID.
- Sits between the command sources and the ALU datapath.

Parameters:
- INPUT, 8, operand width; ALU result width is 2*INPUT.
- ALU_LAT, 2, clock edges from operands applied to result valid, normal ops.
- MUL_LAT, 3, same as ALU_LAT, for MODE=1 with CMD=4'b1001 or 4'b1010.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- REQ0, REQ1  input  1 each  request; held high with bundle stable until the matching GNT.
- REQ0_OPA, REQ0_OPB, REQ1_OPA, REQ1_OPB  input  INPUT each  operands.
- REQ0_CMD, REQ1_CMD  input  4 each  ALU command.
- REQ0_MODE, REQ0_CIN, REQ1_MODE, REQ1_CIN  input  1 each  ALU mode and carry-in.
- REQ0_VALID, REQ1_VALID  input  2 each  operand-valid bits, passed to the ALU unchanged.
- GNT0, GNT1  output  1 each  one-cycle pulse; the bundle has been latched.
- ALU_OPA, ALU_OPB  output  INPUT each  driven operands.
- ALU_CMD  output  4  driven command.
- ALU_VALID  output  2  driven valid bits.
- ALU_MODE, ALU_CIN, ALU_CE  output  1 each  ALU controls.
- ALU_RES  input  2*INPUT  ALU result.
- ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR  input  1 each  ALU flags.
- RES  output  2*INPUT  captured result.
- COUT, OFLOW, G, E, L, ERR  output  1 each  captured flags.
- DONE  output  1  one-cycle pulse; result outputs valid.
- DONE_ID  output  1  requester served (0 or 1).
- BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs 0, including GNT0/1, DONE, DONE_ID, BUSY, ALU_CE, ALU_VALID=2'b00, RES and all flags.
  - State = IDLE; round-robin pointer LAST=1, so REQ0 wins the first tie.
- Reset mid-operation aborts the transaction: no DONE is produced, and the requester must re-request.
- IDLE:
  - REQ0 and REQ1 are sampled each edge.
  - Winner: the only active request, or on a tie the requester != LAST.
  - On the granting edge, all registered together:
    - GNTn=1.
    - ALU_* loaded from the winner's bundle, ALU_CE=1.
    - Down-counter loaded with MUL_LAT if (MODE=1 and CMD in {1001,1010}), else ALU_LAT.
    - LAST=n; state -> WAIT.
- WAIT:
  - GNT returns to 0 after one cycle; ALU_* and ALU_CE=1 are held stable.
  - Counter decrements on each edge; at 0, state -> CAPTURE.
  - Requests are ignored; REQs stay pending and no GNT is issued.
- CAPTURE:
  - Latches ALU_RES and the ALU flags into RES/flags.
  - DONE=1 for exactly one cycle; DONE_ID=LAST.
  - ALU_CE=0; state -> IDLE.
- Latency:
  - DONE is asserted lat+1 cycles after GNT: cycle GNT+3 for normal ops, GNT+4 for multiply.
  - Back-to-back throughput: one op per lat+2 cycles.
- RES and flags hold their values until the next CAPTURE. No arithmetic is performed here; ERR, OFLOW and COUT are pure pass-through captures.
- A REQ dropped before its GNT causes no transaction.
- A REQ still high on the cycle after its GNT is treated as a new request. Requesters must deassert in the GNT cycle.
- ALU_VALID is forwarded unchanged, including 2'b00.
- ALU_CE is driven low only in IDLE and CAPTURE.

Test Plan:
- Release reset; REQ0 with OPA=1, OPB=1, MODE=1, CMD=0000, VALID=11 -> GNT0 pulse; DONE at GNT+3; RES=2, DONE_ID=0, ERR=0.
- REQ1 with OPA=255, OPB=255, MODE=1, CMD=1001, VALID=11 -> DONE at GNT+4; RES=16'hFE01, DONE_ID=1.
- REQ0 and REQ1 raised on the same cycle after reset -> GNT0 first, GNT1 only after the first DONE. Repeat the tie -> GNT0 (alternation holds).
- REQ0 with OPA=-128, OPB=-1, MODE=1, CMD=1011, VALID=11 -> OFLOW=1 captured; DONE at GNT+3.
- REQ0 with OPA=1, OPB=1, CMD=0000, VALID=00 -> ALU_VALID=00 on the ALU port; ERR=1 captured.
- Start a multiply, then drive RST=0 during WAIT -> every output is 0 immediately, BUSY=0, and no DONE follows; a subsequent request completes normally.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: grants a request,
// latches its operand bundle onto the ALU, waits the op latency, then returns the result.
module alu_req_arbiter #(
  parameter int INPUT   = 8,
  parameter int ALU_LAT = 2,
  parameter int MUL_LAT = 3
) (
  input  logic               CLK,
  input  logic               RST,
  // REQn is held high with its bundle stable until GNTn pulses; the requester
  // drops REQn during the GNTn cycle, otherwise it counts as a fresh request.
  input  logic               REQ0,
  input  logic               REQ1,
  input  logic [INPUT-1:0]   REQ0_OPA,
  input  logic [INPUT-1:0]   REQ0_OPB,
  input  logic [INPUT-1:0]   REQ1_OPA,
  input  logic [INPUT-1:0]   REQ1_OPB,
  input  logic [3:0]         REQ0_CMD,
  input  logic [3:0]         REQ1_CMD,
  input  logic               REQ0_MODE,
  input  logic               REQ0_CIN,
  input  logic               REQ1_MODE,
  input  logic               REQ1_CIN,
  input  logic [1:0]         REQ0_VALID,
  input  logic [1:0]         REQ1_VALID,
  output logic               GNT0,
  output logic               GNT1,
  output logic [INPUT-1:0]   ALU_OPA,
  output logic [INPUT-1:0]   ALU_OPB,
  output logic [3:0]         ALU_CMD,
  output logic [1:0]         ALU_VALID,
  output logic               ALU_MODE,
  output logic               ALU_CIN,
  output logic               ALU_CE,
  input  logic [2*INPUT-1:0] ALU_RES,
  input  logic               ALU_COUT,
  input  logic               ALU_OFLOW,
  input  logic               ALU_G,
  input  logic               ALU_E,
  input  logic               ALU_L,
  input  logic               ALU_ERR,
  output logic [2*INPUT-1:0] RES,
  output logic               COUT,
  output logic               OFLOW,
  output logic               G,
  output logic               E,
  output logic               L,
  output logic               ERR,
  output logic               DONE,
  output logic               DONE_ID,
  output logic               BUSY,
  output logic [1:0]         DBG_STATE
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;

  logic             any_req;
  logic             pick1;
  logic [INPUT-1:0] sel_opa;
  logic [INPUT-1:0] sel_opb;
  logic [3:0]       sel_cmd;
  logic             sel_mode;
  logic             sel_cin;
  logic [1:0]       sel_valid;
  logic             sel_is_mul;

  // A tie goes to whichever requester was not served last.
  assign any_req    = REQ0 | REQ1;
  assign pick1      = REQ1 & (~REQ0 | ~last);
  assign sel_opa    = pick1 ? REQ1_OPA   : REQ0_OPA;
  assign sel_opb    = pick1 ? REQ1_OPB   : REQ0_OPB;
  assign sel_cmd    = pick1 ? REQ1_CMD   : REQ0_CMD;
  assign sel_mode   = pick1 ? REQ1_MODE  : REQ0_MODE;
  assign sel_cin    = pick1 ? REQ1_CIN   : REQ0_CIN;
  assign sel_valid  = pick1 ? REQ1_VALID : REQ0_VALID;
  assign sel_is_mul = sel_mode & ((sel_cmd == 4'b1001) | (sel_cmd == 4'b1010));

  assign BUSY      = (state != IDLE);
  assign DBG_STATE = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      ALU_OPA   <= '0;
      ALU_OPB   <= '0;
      ALU_CMD   <= '0;
      ALU_VALID <= 2'b00;
      ALU_MODE  <= 1'b0;
      ALU_CIN   <= 1'b0;
      ALU_CE    <= 1'b0;
      RES       <= '0;
      COUT      <= 1'b0;
      OFLOW     <= 1'b0;
      G         <= 1'b0;
      E         <= 1'b0;
      L         <= 1'b0;
      ERR       <= 1'b0;
      DONE      <= 1'b0;
      DONE_ID   <= 1'b0;
    end else begin
      GNT0 <= 1'b0;
      GNT1 <= 1'b0;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            GNT0      <= ~pick1;
            GNT1      <= pick1;
            ALU_OPA   <= sel_opa;
            ALU_OPB   <= sel_opb;
            ALU_CMD   <= sel_cmd;
            ALU_VALID <= sel_valid;
            ALU_MODE  <= sel_mode;
            ALU_CIN   <= sel_cin;
            ALU_CE    <= 1'b1;
            cnt       <= sel_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
            last      <= pick1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // The result is valid on the edge that empties the counter.
          if (cnt <= CNT_W'(1)) begin
            cnt    <= '0;
            ALU_CE <= 1'b0;
            state  <= CAPTURE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CAPTURE: begin
          RES     <= ALU_RES;
          COUT    <= ALU_COUT;
          OFLOW   <= ALU_OFLOW;
          G       <= ALU_G;
          E       <= ALU_E;
          L       <= ALU_L;
          ERR     <= ALU_ERR;
          DONE    <= 1'b1;
          DONE_ID <= last;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a behavioural ALU drives the DUT's ALU port, and a
// transaction-level model predicts grant order, DONE timing and captured results.
module tb_alu_req_arbiter;

  localparam int W  = 8;
  localparam int EW = 2 * W + 7;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic           REQ0, REQ1;
  logic [W-1:0]   b_opa [2];
  logic [W-1:0]   b_opb [2];
  logic [3:0]     b_cmd [2];
  logic           b_mode [2];
  logic           b_cin [2];
  logic [1:0]     b_valid [2];
  logic           GNT0, GNT1;
  logic [W-1:0]   ALU_OPA, ALU_OPB;
  logic [3:0]     ALU_CMD;
  logic [1:0]     ALU_VALID;
  logic           ALU_MODE, ALU_CIN, ALU_CE;
  logic [2*W-1:0] ALU_RES;
  logic           ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;
  logic [2*W-1:0] RES;
  logic           COUT, OFLOW, G, E, L, ERR;
  logic           DONE, DONE_ID, BUSY;
  logic [1:0]     DBG_STATE;

  alu_req_arbiter #(.INPUT(W), .ALU_LAT(2), .MUL_LAT(3)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .REQ0_OPA(b_opa[0]), .REQ0_OPB(b_opb[0]), .REQ1_OPA(b_opa[1]), .REQ1_OPB(b_opb[1]),
    .REQ0_CMD(b_cmd[0]), .REQ1_CMD(b_cmd[1]),
    .REQ0_MODE(b_mode[0]), .REQ0_CIN(b_cin[0]), .REQ1_MODE(b_mode[1]), .REQ1_CIN(b_cin[1]),
    .REQ0_VALID(b_valid[0]), .REQ1_VALID(b_valid[1]),
    .GNT0(GNT0), .GNT1(GNT1),
    .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD), .ALU_VALID(ALU_VALID),
    .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN), .ALU_CE(ALU_CE),
    .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW),
    .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR),
    .DONE(DONE), .DONE_ID(DONE_ID), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // Behavioural ALU: returns {res, cout, oflow, g, e, l, err}.
  function automatic logic [2*W+5:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] cmd, input logic mode,
                                            input logic cin, input logic [1:0] valid);
    logic [2*W-1:0] r, xa, xb;
    logic [W-1:0]   s;
    logic           co, of, g, e, l, er;
    r = '0; co = 1'b0; of = 1'b0; g = 1'b0; e = 1'b0; l = 1'b0; er = 1'b0; s = '0;
    xa = {{W{1'b0}}, a};
    xb = {{W{1'b0}}, b};
    if (valid != 2'b11) begin
      er = 1'b1;
    end else if (mode) begin
      case (cmd)
        4'b0000: begin r = xa + xb + {{(2*W-1){1'b0}}, cin}; co = r[W]; end
        4'b0001: begin r = xa - xb; co = (a < b); end
        4'b1000: begin g = (a > b); e = (a == b); l = (a < b); end
        4'b1001: r = xa * xb;
        4'b1010: r = (xa << 1) * xb;
        4'b1011: begin
          s  = a + b;
          of = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
          r  = {{W{s[W-1]}}, s};
        end
        default: er = 1'b1;
      endcase
    end else begin
      case (cmd)
        4'b0000: r = {{W{1'b0}}, a & b};
        4'b0001: r = {{W{1'b0}}, a | b};
        4'b0010: r = {{W{1'b0}}, a ^ b};
        default: er = 1'b1;
      endcase
    end
    return {r, co, of, g, e, l, er};
  endfunction

  assign {ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR} =
    alu_fn(ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_VALID);

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int  cyc = 0;
  int  done_cyc = 0;
  int  gnt_cyc = 0;
  int  lat_seen = 0;
  int  n_gnt = 0;
  int  n_done = 0;
  int  last_gnt = 0;
  int  last_id = 1;
  bit  outstanding = 1'b0;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (RST) begin
        bit idle_prev;
        int exp_id;
        idle_prev = !outstanding || (cyc - 1 >= done_cyc);
        if (REQ0 || REQ1 || GNT0 || GNT1) begin
          if (idle_prev && (REQ0 || REQ1)) begin
            // Among pending requesters, the one not served most recently wins.
            if (REQ0 && REQ1) exp_id = (last_id == 1) ? 0 : 1;
            else              exp_id = REQ1 ? 1 : 0;
            check("gnt0", 64'(GNT0), 64'(exp_id == 0));
            check("gnt1", 64'(GNT1), 64'(exp_id == 1));
            check("alu_opa", 64'(ALU_OPA), 64'(b_opa[exp_id]));
            check("alu_opb", 64'(ALU_OPB), 64'(b_opb[exp_id]));
            check("alu_ctl", 64'({ALU_CMD, ALU_MODE, ALU_CIN, ALU_VALID}),
                  64'({b_cmd[exp_id], b_mode[exp_id], b_cin[exp_id], b_valid[exp_id]}));
            exp_q.push_back({1'(exp_id), alu_fn(b_opa[exp_id], b_opb[exp_id], b_cmd[exp_id],
                                                b_mode[exp_id], b_cin[exp_id], b_valid[exp_id])});
            done_cyc = cyc + 1 + ((b_mode[exp_id] && (b_cmd[exp_id] == 4'b1001 ||
                                   b_cmd[exp_id] == 4'b1010)) ? 3 : 2);
            outstanding = 1'b1;
            last_id  = exp_id;
            last_gnt = exp_id;
            gnt_cyc  = cyc;
            n_gnt++;
          end else begin
            check("gnt_while_busy", 64'({GNT0, GNT1}), 64'(0));
          end
        end
        check("busy", 64'(BUSY), 64'(outstanding && cyc < done_cyc));
        check("alu_ce", 64'(ALU_CE), 64'(outstanding && cyc < done_cyc - 1));
        if (DONE) begin
          n_done++;
          if (exp_q.size() == 0) begin
            check("done_spurious", 64'(DONE), 64'(0));
          end else begin
            logic [EW-1:0] ex;
            ex = exp_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(done_cyc));
            check("done_id", 64'(DONE_ID), 64'(ex[EW-1]));
            check("res", 64'(RES), 64'(ex[EW-2:6]));
            check("flags", 64'({COUT, OFLOW, G, E, L, ERR}), 64'(ex[5:0]));
            lat_seen = cyc - gnt_cyc;
          end
          outstanding = 1'b0;
        end else if (outstanding && cyc >= done_cyc) begin
          check("done_missing", 64'(DONE), 64'(1));
          void'(exp_q.pop_front());
          outstanding = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge CLK);
    if (GNT0) REQ0 = 1'b0;
    if (GNT1) REQ1 = 1'b0;
  endtask

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] cmd, input logic mode, input logic cin,
                       input logic [1:0] valid);
    b_opa[id] = a; b_opb[id] = b; b_cmd[id] = cmd;
    b_mode[id] = mode; b_cin[id] = cin; b_valid[id] = valid;
    if (id == 0) REQ0 = 1'b1;
    else         REQ1 = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int k = 0;
    while ((REQ0 || REQ1 || outstanding) && k < budget) begin
      step();
      k++;
    end
    check("quiet_timeout", 64'(k < budget), 64'(1));
  endtask

  task automatic wait_gnt(input int target);
    int k = 0;
    while (n_gnt < target && k < 50) begin
      step();
      k++;
    end
    check("gnt_timeout", 64'(n_gnt >= target), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] cmd_tab [8];
  int         g0;

  initial begin
    cmd_tab = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0010, 4'b1111};
    REQ0 = 1'b0; REQ1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_opa[i] = '0; b_opb[i] = '0; b_cmd[i] = '0;
      b_mode[i] = 1'b0; b_cin[i] = 1'b0; b_valid[i] = 2'b00;
    end
    repeat (3) @(negedge CLK);
    check("rst_ctl", 64'({GNT0, GNT1, DONE, DONE_ID, BUSY, ALU_CE, ALU_VALID, DBG_STATE}), 64'(0));
    check("rst_res", 64'({RES, COUT, OFLOW, G, E, L, ERR}), 64'(0));
    RST = 1'b1;

    // normal add
    issue(0, 8'd1, 8'd1, 4'b0000, 1'b1, 1'b0, 2'b11);
    wait_quiet(50);
    check("t1_res", 64'(RES), 64'(16'd2));
    check("t1_id", 64'(DONE_ID), 64'(0));
    check("t1_err", 64'(ERR), 64'(0));
    check("t1_lat", 64'(lat_seen), 64'(3));

    // multiply
    issue(1, 8'd255, 8'd255, 4'b1001, 1'b1, 1'b0, 2'b11);
    wait_quiet(50);
    check("t2_res", 64'(RES), 64'(16'hFE01));
    check("t2_id", 64'(DONE_ID), 64'(1));
    check("t2_lat", 64'(lat_seen), 64'(4));

    // ties alternate
    for (int r = 0; r < 2; r++) begin
      g0 = n_gnt;
      issue(0, 8'd3, 8'd4, 4'b0000, 1'b1, 1'b0, 2'b11);
      issue(1, 8'd7, 8'd5, 4'b0001, 1'b1, 1'b0, 2'b11);
      wait_gnt(g0 + 1);
      check("tie_first", 64'(last_gnt), 64'(0));
      wait_gnt(g0 + 2);
      check("tie_second", 64'(last_gnt), 64'(1));
      wait_quiet(50);
    end

    // invalid operands pass through and raise ERR
    issue(0, 8'd1, 8'd1, 4'b0000, 1'b1, 1'b0, 2'b00);
    wait_gnt(n_gnt + 1);
    check("t5_alu_valid", 64'(ALU_VALID), 64'(2'b00));
    wait_quiet(50);
    check("t5_err", 64'(ERR), 64'(1));

    // signed overflow
    issue(0, 8'h80, 8'hFF, 4'b1011, 1'b1, 1'b0, 2'b11);
    wait_quiet(50);
    check("t4_oflow", 64'(OFLOW), 64'(1));
    check("t4_lat", 64'(lat_seen), 64'(3));

    // reset during WAIT aborts the multiply
    issue(1, 8'd200, 8'd100, 4'b1001, 1'b1, 1'b0, 2'b11);
    wait_gnt(n_gnt + 1);
    step();
    step();
    RST = 1'b0;
    #1;
    exp_q.delete();
    outstanding = 1'b0;
    last_id = 1;
    check("t6_ctl", 64'({GNT0, GNT1, DONE, DONE_ID, BUSY, ALU_CE, ALU_VALID, DBG_STATE}), 64'(0));
    check("t6_alu", 64'({ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN}), 64'(0));
    check("t6_res", 64'({RES, COUT, OFLOW, G, E, L, ERR}), 64'(0));
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (2) step();
    RST = 1'b1;
    g0 = n_done;
    repeat (8) step();
    check("t6_no_done", 64'(n_done - g0), 64'(0));
    issue(1, 8'd2, 8'd3, 4'b1001, 1'b1, 1'b0, 2'b11);
    wait_quiet(50);
    check("t6_res_after", 64'(RES), 64'(16'd6));
    check("t6_lat_after", 64'(lat_seen), 64'(4));

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      step();
      for (int id = 0; id < 2; id++) begin
        logic rq, gn;
        rq = (id == 0) ? REQ0 : REQ1;
        gn = (id == 0) ? GNT0 : GNT1;
        if (!rq && !gn && $urandom_range(0, 3) == 0)
          issue(id, W'($urandom), W'($urandom), cmd_tab[$urandom_range(0, 7)],
                1'($urandom_range(0, 3) != 0), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11);
      end
    end
    wait_quiet(100);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
